// File: rtl/uart_io_pkg.sv
// Shared encodings for the UART word/byte sequencer: size codes and TX/RX engine states.
package uart_io_pkg;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_3B = 2'b10;
    localparam logic [1:0] SZ_4B = 2'b11;

    typedef enum logic [1:0] {
        T_IDLE = 2'b00,
        T_SEND = 2'b01,
        T_DONE = 2'b10
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'b00,
        R_COLLECT = 2'b01,
        R_DONE    = 2'b10
    } rx_state_t;

    // Byte idx of a word, idx 0 = least significant.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with registered read; rd_valid marks the byte popped on the previous cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  rd_data_reg;
    logic        rd_valid_reg;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
        if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            rd_valid_reg <= pop_ok;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/uart_io_ctrl.sv
// Word-to-byte UART sequencer: independent TX (MSB-first serializer) and RX (assembler) engines.
// Optional RX byte buffer between PHY and RX engine is enabled with `define UART_RX_FIFO_EN.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 16,
    parameter int TX_GAP        = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [1:0]  uart_wsz,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    input  logic [1:0]  uart_rsz,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        req_ovr
);
    localparam int GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    tx_state_t          tx_state_reg, tx_state_next;
    logic [1:0]         tx_cnt_reg, tx_cnt_next;
    logic [31:0]        tx_word_reg, tx_word_next;
    logic [GAP_W-1:0]   tx_gap_reg, tx_gap_next;
    logic               tx_fire;

    rx_state_t          rx_state_reg, rx_state_next;
    logic [1:0]         rx_cnt_reg, rx_cnt_next;
    logic [23:0]        rx_sh_reg, rx_sh_next;
    logic [31:0]        rd_reg, rd_next;
    logic               rx_byte_valid;
    logic [7:0]         rx_byte;
    logic               req_ovr_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_reg <= T_IDLE;
            tx_cnt_reg   <= '0;
            tx_word_reg  <= '0;
            tx_gap_reg   <= '0;
            rx_state_reg <= R_IDLE;
            rx_cnt_reg   <= '0;
            rx_sh_reg    <= '0;
            rd_reg       <= '0;
            req_ovr_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_word_reg  <= tx_word_next;
            tx_gap_reg   <= tx_gap_next;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_sh_reg    <= rx_sh_next;
            rd_reg       <= rd_next;
            if ((uart_wenable && tx_state_reg != T_IDLE) ||
                (uart_renable && rx_state_reg != R_IDLE)) begin
                req_ovr_reg <= 1'b1;
            end
        end
    end

    // TX engine: tx_cnt indexes the byte on the wire, counting down from wsz.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_word_next  = tx_word_reg;
        tx_gap_next   = tx_gap_reg;
        tx_valid      = (tx_state_reg == T_SEND) && (tx_gap_reg == '0);
        tx_fire       = tx_valid && tx_ready;
        uart_wdone    = (tx_state_reg == T_DONE);
        case (tx_state_reg)
            T_IDLE: begin
                if (uart_wenable) begin
                    tx_word_next  = uart_wd;
                    tx_cnt_next   = uart_wsz;
                    tx_gap_next   = '0;
                    tx_state_next = T_SEND;
                end
            end
            T_SEND: begin
                if (tx_gap_reg != '0) begin
                    tx_gap_next = tx_gap_reg - GAP_W'(1);
                end else if (tx_fire) begin
                    if (tx_cnt_reg == SZ_1B) begin
                        tx_state_next = T_DONE;
                    end else begin
                        tx_cnt_next = tx_cnt_reg - 2'd1;
                        tx_gap_next = GAP_W'(TX_GAP);
                    end
                end
            end
            T_DONE:  tx_state_next = T_IDLE;
            default: tx_state_next = T_IDLE;
        endcase
    end

    assign tx_data = byte_sel(tx_word_reg, tx_cnt_reg);

`ifdef UART_RX_FIFO_EN
    logic       rx_en_reg;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [2:0] rx_pop_left_reg, rx_pop_left_next;

    // Pops are budgeted separately from consumed bytes because the read takes a cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_en_reg       <= 1'b0;
            rx_pop_left_reg <= '0;
        end else begin
            rx_en_reg       <= 1'b1;
            rx_pop_left_reg <= rx_pop_left_next;
        end
    end

    always_comb begin
        rx_pop_left_next = rx_pop_left_reg;
        if (uart_renable && rx_state_reg == R_IDLE) begin
            rx_pop_left_next = {1'b0, uart_rsz} + 3'd1;
        end else if (fifo_pop) begin
            rx_pop_left_next = rx_pop_left_reg - 3'd1;
        end
    end

    assign rx_ready = rx_en_reg && !fifo_full;
    assign fifo_pop = (rx_state_reg == R_COLLECT) && !fifo_empty && (rx_pop_left_reg != 3'd0);

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (rx_valid && rx_ready),
        .wr_data  (rx_data),
        .pop      (fifo_pop),
        .rd_data  (rx_byte),
        .rd_valid (rx_byte_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
`else
    logic cfg_unused;

    assign cfg_unused    = (RX_FIFO_DEPTH > 0);
    assign rx_ready      = (rx_state_reg == R_COLLECT);
    assign rx_byte_valid = rx_valid && rx_ready;
    assign rx_byte       = rx_data;
`endif

    // RX engine: shift register starts at zero so short transfers come out zero-extended.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_sh_next    = rx_sh_reg;
        rd_next       = rd_reg;
        uart_rdone    = (rx_state_reg == R_DONE);
        case (rx_state_reg)
            R_IDLE: begin
                if (uart_renable) begin
                    rx_cnt_next   = uart_rsz;
                    rx_sh_next    = '0;
                    rx_state_next = R_COLLECT;
                end
            end
            R_COLLECT: begin
                if (rx_byte_valid) begin
                    rx_sh_next = {rx_sh_reg[15:0], rx_byte};
                    if (rx_cnt_reg == SZ_1B) begin
                        rd_next       = {rx_sh_reg, rx_byte};
                        rx_state_next = R_DONE;
                    end else begin
                        rx_cnt_next = rx_cnt_reg - 2'd1;
                    end
                end
            end
            R_DONE:  rx_state_next = R_IDLE;
            default: rx_state_next = R_IDLE;
        endcase
    end

    assign uart_rd = rd_reg;
    assign req_ovr = req_ovr_reg;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Randomized self-checking bench for uart_io_ctrl against a queue-based byte-stream model.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        uart_wenable, uart_renable;
    logic [1:0]  uart_wsz, uart_rsz;
    logic [31:0] uart_wd, uart_rd;
    logic        uart_wdone, uart_rdone;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, req_ovr;

    uart_io_ctrl #(
        .RX_FIFO_DEPTH (16),
        .TX_GAP        (0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_wenable (uart_wenable),
        .uart_wsz     (uart_wsz),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rsz     (uart_rsz),
        .uart_rd      (uart_rd),
        .uart_rdone   (uart_rdone),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .req_ovr      (req_ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  rx_model_q[$];
    logic [31:0] rd_exp_q[$];
    int exp_wdone = 0, exp_rdone = 0;
    int wdone_cnt = 0, rdone_cnt = 0, rx_took_cnt = 0;
    int tx_mode = 1;
    bit rx_gaps = 1'b0;

    task automatic model_out(input logic [1:0] sz, input logic [31:0] wd);
        for (int i = int'(sz); i >= 0; i--) begin
            logic [31:0] t;
            t = wd >> (8 * i);
            tx_exp_q.push_back(t[7:0]);
        end
        exp_wdone++;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        rx_model_q.push_back(b);
    endtask

    task automatic model_in(input logic [1:0] sz, output logic [31:0] v);
        v = 32'd0;
        for (int i = 0; i <= int'(sz); i++) begin
            v = (v << 8) | {24'd0, rx_model_q.pop_front()};
        end
        rd_exp_q.push_back(v);
        exp_rdone++;
    endtask

    task automatic issue(input bit w, input logic [1:0] wsz_i, input logic [31:0] wd_i,
                         input bit r, input logic [1:0] rsz_i);
        @(posedge clk);
        #1;
        uart_wenable = w;
        uart_wsz     = wsz_i;
        uart_wd      = wd_i;
        uart_renable = r;
        uart_rsz     = rsz_i;
        $display("REQ t=%0t out=%0d wsz=%0d wd=%h in=%0d rsz=%0d", $time, w, wsz_i, wd_i, r, rsz_i);
        @(posedge clk);
        #1;
        uart_wenable = 1'b0;
        uart_renable = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while ((wdone_cnt != exp_wdone || rdone_cnt != exp_rdone) && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check_eq({tag, "_wdone_cnt"}, wdone_cnt, exp_wdone);
        check_eq({tag, "_rdone_cnt"}, rdone_cnt, exp_rdone);
    endtask

    // PHY-side TX acceptor
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // PHY-side RX source: holds each byte until it is taken
    initial begin
        bit took;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        forever begin
            @(negedge clk);
            took = rstn && rx_valid && rx_ready;
            @(posedge clk);
            #2;
            if (took) begin
                void'(rx_q.pop_front());
                rx_valid = 1'b0;
                rx_took_cnt++;
            end
            if (!rx_valid && rx_q.size() > 0 && (!rx_gaps || $urandom_range(0, 2) != 0)) begin
                rx_valid = 1'b1;
                rx_data  = rx_q[0];
            end
        end
    end

    // Monitor / scoreboard
    bit          hold = 1'b0, prev_wdone = 1'b0, prev_rdone = 1'b0;
    logic [7:0]  hold_data = 8'd0;
    logic [31:0] last_rd = 32'd0;
    always @(negedge clk) begin
        if (!rstn) begin
            hold       = 1'b0;
            prev_wdone = 1'b0;
            prev_rdone = 1'b0;
            last_rd    = 32'd0;
        end else begin
            if (hold) begin
                check_eq("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                check_eq("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_exp_q.size() > 0) check_eq("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
                else                     check_eq("tx_byte_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end
            if (uart_wdone) begin
                wdone_cnt++;
                check_eq("wdone_pending_bytes", tx_exp_q.size(), 32'd0);
                check_eq("wdone_pulse", {31'd0, prev_wdone}, 32'd0);
            end
            if (uart_rdone) begin
                rdone_cnt++;
                if (rd_exp_q.size() > 0) check_eq("uart_rd", uart_rd, rd_exp_q.pop_front());
                else                     check_eq("uart_rd_unexpected", uart_rd, ~uart_rd);
                check_eq("rdone_pulse", {31'd0, prev_rdone}, 32'd0);
                last_rd = uart_rd;
            end else begin
                check_eq("uart_rd_hold", uart_rd, last_rd);
            end
            prev_wdone = uart_wdone;
            prev_rdone = uart_rdone;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, wd;
        logic [1:0]  wsz, rsz;
        int          kind, took0;

        rstn = 1'b0;
        uart_wenable = 1'b0; uart_renable = 1'b0;
        uart_wsz = 2'd0; uart_rsz = 2'd0; uart_wd = 32'd0;
        tx_mode = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_wdone", {31'd0, uart_wdone}, 32'd0);
        check_eq("rst_rdone", {31'd0, uart_rdone}, 32'd0);
        check_eq("rst_uart_rd", uart_rd, 32'd0);
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_req_ovr", {31'd0, req_ovr}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four-byte OUT, MSB first, back to back, wdone right after
        model_out(2'b11, 32'h41424344);
        issue(1'b1, 2'b11, 32'h41424344, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t1_tx_valid", {31'd0, tx_valid}, 32'd1);
            check_eq("t1_tx_data", {24'd0, tx_data}, 32'h41 + i);
            check_eq("t1_wdone_early", {31'd0, uart_wdone}, 32'd0);
        end
        @(negedge clk);
        check_eq("t1_wdone", {31'd0, uart_wdone}, 32'd1);
        check_eq("t1_tx_valid_after", {31'd0, tx_valid}, 32'd0);
        wait_done("t1");

        // 2: one byte with PHY stalling three cycles
        tx_mode = 0;
        model_out(2'b00, 32'h0000005A);
        issue(1'b1, 2'b00, 32'h0000005A, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t2_tx_valid", {31'd0, tx_valid}, 32'd1);
            check_eq("t2_tx_data", {24'd0, tx_data}, 32'h5A);
            check_eq("t2_wdone", {31'd0, uart_wdone}, 32'd0);
        end
        tx_mode = 1;
        wait_done("t2");

        // 3: two-byte IN, first byte lands most significant
        feed(8'h12);
        feed(8'h34);
        model_in(2'b01, v);
        issue(1'b0, 2'b00, 32'd0, 1'b1, 2'b01);
        wait_done("t3");
        check_eq("t3_uart_rd", uart_rd, 32'h00001234);

        // 4: second IN while collecting is dropped and flagged
        check_eq("t4_req_ovr_before", {31'd0, req_ovr}, 32'd0);
        issue(1'b0, 2'b00, 32'd0, 1'b1, 2'b11);
        repeat (3) @(negedge clk);
        issue(1'b0, 2'b00, 32'd0, 1'b1, 2'b00);
        @(negedge clk);
        check_eq("t4_req_ovr", {31'd0, req_ovr}, 32'd1);
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        model_in(2'b11, v);
        wait_done("t4");
        check_eq("t4_req_ovr_sticky", {31'd0, req_ovr}, 32'd1);

        // 5: reset after two of four TX bytes
        tx_mode = 1;
        model_out(2'b11, 32'hA1B2C3D4);
        issue(1'b1, 2'b11, 32'hA1B2C3D4, 1'b0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_eq("t5_tx_valid_rst", {31'd0, tx_valid}, 32'd0);
        check_eq("t5_req_ovr_rst", {31'd0, req_ovr}, 32'd0);
        check_eq("t5_bytes_left", tx_exp_q.size(), 32'd2);
        tx_exp_q.delete();
        exp_wdone--;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        wd = $urandom;
        model_out(2'b01, wd);
        issue(1'b1, 2'b01, wd, 1'b0, 2'b00);
        wait_done("t5");

        // Randomized concurrent OUT/IN traffic with PHY stalls
        tx_mode = 2;
        rx_gaps = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            wsz  = 2'($urandom);
            rsz  = 2'($urandom);
            wd   = $urandom;
            if (kind != 1) model_out(wsz, wd);
            if (kind != 0) begin
                for (int b = 0; b <= int'(rsz); b++) feed(8'($urandom));
                model_in(rsz, v);
            end
            issue(kind != 1, wsz, wd, kind != 0, rsz);
            wait_done("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef UART_RX_FIFO_EN
        // 6: bytes buffered while RX idle, back-pressure at depth
        rx_gaps = 1'b0;
        took0 = rx_took_cnt;
        for (int i = 0; i < 20; i++) feed(8'($urandom));
        repeat (30) @(negedge clk);
        check_eq("t6_buffered", rx_took_cnt - took0, 32'd16);
        check_eq("t6_rx_ready_full", {31'd0, rx_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            model_in(2'b11, v);
            issue(1'b0, 2'b00, 32'd0, 1'b1, 2'b11);
            wait_done("t6");
        end
`else
        took0 = rx_took_cnt;
`endif
        check_eq("rx_stream_drained", rx_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
